// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans NUM_CHANNELS inputs of an ADC0808-style ADC once per SCAN_INTERVAL clocks.
// Ports: clk, rst (async, active high), enable, adc_eoc (raw, synchronised here), adc_data;
//        adc_addr/adc_ale/adc_start/adc_oe drive the ADC; sample_data/sample_chan/sample_valid
//        publish results; scan_done, busy, timeout_err and overrun report sequencing status.
// Build option ADC_FILTER_EN: each sample is averaged with that channel's previous raw result.
module adc_scan_sequencer #(
  parameter int NUM_CHANNELS  = 5,
  parameter int SCAN_INTERVAL = 1_000_000,
  parameter int START_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int EOC_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       adc_eoc,
  input  logic [7:0] adc_data,
  output logic [2:0] adc_addr,
  output logic       adc_ale,
  output logic       adc_start,
  output logic       adc_oe,
  output logic [7:0] sample_data,
  output logic [2:0] sample_chan,
  output logic       sample_valid,
  output logic       scan_done,
  output logic       busy,
  output logic       timeout_err,
  output logic       overrun
);
  localparam int IW = $clog2(SCAN_INTERVAL);
  localparam int TS = START_CYCLES > SETTLE_CYCLES ? START_CYCLES : SETTLE_CYCLES;
  localparam int TM = EOC_TIMEOUT > TS ? EOC_TIMEOUT : TS;
  localparam int CW = $clog2(TM + 1);
  localparam logic [CW-1:0] SET_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STA_END = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TO_END  = CW'(EOC_TIMEOUT - 1);
  localparam logic [2:0]    CH_END  = 3'(NUM_CHANNELS - 1);
  localparam logic [IW-1:0] IV_END  = IW'(SCAN_INTERVAL - 1);
  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT_LO, WAIT_HI, READ, NEXT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ival_q, ival_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] chan_q, chan_d, addr_q, addr_d, schan_q, schan_d;
  logic [1:0] eoc_q, eoc_d;
  logic [7:0] data_q, data_d, res;
  logic abort_q, abort_d, ale_q, ale_d, oe_q, oe_d, busy_q, busy_d;
  logic valid_q, valid_d, done_q, done_d, terr_q, terr_d, ovr_q, ovr_d;
  logic tick, cap, eoc_s;
  assign eoc_s = eoc_q[1];
  assign tick  = ival_q == IV_END;
  assign cap   = state_q == READ && cnt_q == SET_END;
`ifdef ADC_FILTER_EN
  logic [7:0] hist_q [NUM_CHANNELS];
  logic [7:0] hist_d [NUM_CHANNELS];
  always_comb begin
    hist_d = hist_q;
    if (cap) hist_d[chan_q] = adc_data;
  end
  assign res = 8'((9'(hist_q[chan_q]) + 9'(adc_data)) >> 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) hist_q[i] <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign res = adc_data;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    chan_d  = chan_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tick && enable) begin
          state_d = SETUP;
          chan_d  = '0;
        end
      end
      SETUP: if (cnt_q == SET_END) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: if (cnt_q == STA_END) begin
        state_d = WAIT_LO;
        cnt_d   = '0;
      end
      WAIT_LO: if (!eoc_s) begin
        state_d = WAIT_HI;
        cnt_d   = '0;
      end else if (cnt_q == TO_END) begin
        state_d = NEXT;
        abort_d = 1'b1;
      end
      WAIT_HI: if (eoc_s) begin
        state_d = READ;
        cnt_d   = '0;
      end else if (cnt_q == TO_END) begin
        state_d = NEXT;
        abort_d = 1'b1;
      end
      READ: if (cap) begin
        state_d = NEXT;
        abort_d = 1'b0;
      end
      NEXT: begin
        cnt_d   = '0;
        state_d = chan_q == CH_END ? IDLE : SETUP;
        chan_d  = chan_q == CH_END ? chan_q : chan_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so each one is glitch-free and clears with rst.
    ival_d  = tick ? '0 : ival_q + 1'b1;
    eoc_d   = {eoc_q[0], adc_eoc};
    addr_d  = state_d == SETUP ? chan_d : addr_q;
    ale_d   = state_d == START;
    oe_d    = state_d == READ;
    busy_d  = state_d != IDLE;
    valid_d = state_d == NEXT && !abort_d;
    terr_d  = state_d == NEXT && abort_d;
    done_d  = state_d == NEXT && chan_q == CH_END;
    ovr_d   = tick && state_q != IDLE;
    data_d  = cap ? res : data_q;
    schan_d = cap ? chan_q : schan_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ival_q  <= '0;
      cnt_q   <= '0;
      chan_q  <= '0;
      abort_q <= 1'b0;
      eoc_q   <= '0;
      addr_q  <= '0;
      ale_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
      schan_q <= '0;
    end else begin
      state_q <= state_d;
      ival_q  <= ival_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      abort_q <= abort_d;
      eoc_q   <= eoc_d;
      addr_q  <= addr_d;
      ale_q   <= ale_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
      schan_q <= schan_d;
    end
  end
  // ALE and START are the same pulse on an ADC0808.
  assign adc_addr     = addr_q;
  assign adc_ale      = ale_q;
  assign adc_start    = ale_q;
  assign adc_oe       = oe_q;
  assign sample_data  = data_q;
  assign sample_chan  = schan_q;
  assign sample_valid = valid_q;
  assign scan_done    = done_q;
  assign busy         = busy_q;
  assign timeout_err  = terr_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: randomized ADC model plus transaction-level scoreboard for adc_scan_sequencer.
module tb_adc_scan_sequencer;
  localparam int N      = 5;
  localparam int SI     = 1500;
  localparam int START  = 16;
  localparam int SETTLE = 4;
  localparam int TO     = 600;
  typedef struct {
    int         when;
    logic [7:0] data;
    bit         to;
  } ev_t;
  logic clk, rst, enable, adc_eoc;
  logic [7:0] adc_data, sample_data;
  logic [2:0] adc_addr, sample_chan;
  logic adc_ale, adc_start, adc_oe, sample_valid, scan_done, busy, timeout_err, overrun;
  int total, bad, m, exp_chan, setup_m, low_at, rise_at, ale_run, oe_run;
  bit mbusy, end_pend, prev_ale, prev_oe, toggle_en;
  logic [2:0] lat_addr;
  logic [7:0] conv;
  logic [7:0] hist [8];
  ev_t q[$];
  adc_scan_sequencer #(
    .NUM_CHANNELS(N), .SCAN_INTERVAL(SI), .START_CYCLES(START),
    .SETTLE_CYCLES(SETTLE), .EOC_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_eoc(adc_eoc), .adc_data(adc_data),
    .adc_addr(adc_addr), .adc_ale(adc_ale), .adc_start(adc_start), .adc_oe(adc_oe),
    .sample_data(sample_data), .sample_chan(sample_chan), .sample_valid(sample_valid),
    .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h want %0h", tag, $time, act, exp_v);
    end
  endtask
  task automatic model_reset();
    m = 0;
    mbusy = 0;
    end_pend = 0;
    exp_chan = 0;
    setup_m = 0;
    low_at = -1;
    rise_at = -1;
    ale_run = 0;
    oe_run = 0;
    prev_ale = 0;
    prev_oe = 0;
    q.delete();
    adc_eoc = 1;
    for (int i = 0; i < 8; i++) hist[i] = 0;
  endtask
  task automatic check_reset_outs();
    chk("rst_outs", 32'({adc_addr, adc_ale, adc_start, adc_oe, sample_data, sample_chan,
                          sample_valid, scan_done, busy, timeout_err, overrun}), 0);
  endtask
  // One clock: sample just after the edge, score against the model, then drive the ADC side.
  task automatic step();
    bit tick, ev;
    ev_t it;
    int d;
    logic [7:0] v;
    @(posedge clk);
    #1;
    m++;
    tick = ((m - 1) % SI) == SI - 1;
    chk("overrun", overrun, tick && mbusy);
    if (mbusy) mbusy = !end_pend;
    else if (tick && enable) begin
      mbusy = 1;
      exp_chan = 0;
      setup_m = m;
    end
    end_pend = 0;
    chk("busy", busy, mbusy);
    chk("start_eq_ale", adc_start, adc_ale);
    chk("ale_oe_excl", adc_ale & adc_oe, 0);
    if (adc_ale && !prev_ale) begin
      chk("ale_time", m, setup_m + SETTLE);
      chk("ale_addr", adc_addr, exp_chan);
      lat_addr = adc_addr;
    end
    if (!adc_ale && prev_ale) begin
      chk("ale_width", ale_run, START);
      d = $urandom_range(20, 300);
      v = 8'($urandom);
      it.to = $urandom_range(0, 7) == 0;
      it.when = it.to ? m + (adc_eoc ? TO + 6 : TO + 1) : m + 3 + d + 3 + SETTLE;
      low_at = adc_eoc ? m + 3 : -1;
      rise_at = it.to ? -1 : m + 3 + d;
`ifdef ADC_FILTER_EN
      it.data = 8'((9'(hist[lat_addr]) + 9'(v)) >> 1);
      if (!it.to) hist[lat_addr] = v;
`else
      it.data = v;
`endif
      conv = v;
      q.push_back(it);
    end
    if (!adc_oe && prev_oe) chk("oe_width", oe_run, SETTLE);
    ale_run = adc_ale ? ale_run + 1 : 0;
    oe_run = adc_oe ? oe_run + 1 : 0;
    prev_ale = adc_ale;
    prev_oe = adc_oe;
    ev = sample_valid || timeout_err;
    chk("scan_done", scan_done, ev && exp_chan == N - 1);
    if (q.size() > 0 && q[0].when < m) begin
      chk("ev_time", m, q[0].when);
      void'(q.pop_front());
    end
    if (ev) begin
      if (q.size() == 0) chk("ev_spurious", ev, 0);
      else begin
        it = q.pop_front();
        chk("ev_time", m, it.when);
        chk("ev_timeout", timeout_err, it.to);
        chk("ev_valid", sample_valid, !it.to);
        if (sample_valid) begin
          chk("chan", sample_chan, exp_chan);
          chk("data", sample_data, it.data);
        end
      end
      if (exp_chan == N - 1) end_pend = 1;
      else begin
        exp_chan++;
        setup_m = m + 1;
      end
    end
    if (m == low_at) adc_eoc = 0;
    if (m == rise_at) adc_eoc = 1;
    adc_data = adc_oe ? conv : 8'($urandom);
    if (toggle_en && $urandom_range(0, 799) == 0) enable = !enable;
  endtask
  initial begin
    total = 0;
    bad = 0;
    enable = 1;
    adc_data = 0;
    conv = 0;
    lat_addr = 0;
    toggle_en = 1;
    model_reset();
    rst = 0;
    #1 rst = 1;
    #1 check_reset_outs();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    model_reset();
    repeat (25000) step();
    for (int i = 0; i < 6000 && !adc_oe; i++) step();
    chk("reach_read", adc_oe, 1);
    rst = 1;
    #1 check_reset_outs();
    repeat (3) @(posedge clk);
    #2 rst = 0;
    model_reset();
    repeat (25000) step();
    toggle_en = 0;
    enable = 0;
    for (int i = 0; i < 10000 && (mbusy || q.size() > 0); i++) step();
    repeat (5) step();
    chk("drain_busy", busy, 0);
    chk("drain_q", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
